fab_reset_sequencer: RTL and testbench
======================================

# fab_reset_sequencer

Fabric-side reset sequencer for the MSS system block. It gates FAB_RESET_N into CoreResetP until the fabric CCC has held lock for a filtered interval and a fixed hold-off has elapsed. It then waits for MSS_READY and INIT_DONE, retries on timeout and latches a fault after a bounded number of retries. It sits between the system block's FAB_CCC_LOCK/MSS_READY/INIT_DONE outputs and its FAB_RESET_N input, clocked by FAB_CCC_GL0.

## Interface
Reset is synchronous and active-high.

Parameters:
- LOCK_FILTER, 16: consecutive synchronized-lock cycles required before HOLD; ≥2.
- HOLD_CYCLES, 200: cycles FAB_RESET_N stays low in HOLD; ≥2.
- READY_TIMEOUT, 65535: cycles allowed in WAIT_READY before a retry; ≥2.
- MAX_RETRY, 3: timeouts tolerated before FAULT; 0..3.

Ports:
- CLK_BASE  in  1  fabric clock (FAB_CCC_GL0).
- RESET  in  1  synchronous, active-high.
- CCC_LOCK  in  1  FAB_CCC_LOCK; asynchronous to CLK_BASE, 2-flop synchronized.
- MSS_READY  in  1  2-flop synchronized.
- INIT_DONE  in  1  2-flop synchronized.
- SOFT_RESET_REQ  in  1  single-cycle restart request, already synchronous.
- FAB_RESET_N  out  1  to system block FAB_RESET_N; registered.
- SYS_READY  out  1  high only in RUN; registered.
- FAULT  out  1  high only in FAULT; registered.
- STATE  out  3  current state encoding.
- RETRY_CNT  out  2  timeouts since last RUN or fault clear.

## Operation
- Synchronization:
  - lock_s, ready_s and done_s are 2-flop synchronized copies of their inputs.
  - All decisions use the synchronized copies only.
- Counter: one shared counter, width = clog2 of the largest of the three interval parameters. It is cleared on every state change.
- States (encoding 0..4):
  - WAIT_LOCK (0):
    - The counter increments while lock_s=1 and clears while lock_s=0.
    - When counter==LOCK_FILTER-1 and lock_s=1, go to HOLD.
  - HOLD (1):
    - lock_s=0 returns to WAIT_LOCK.
    - When counter==HOLD_CYCLES-1, go to WAIT_READY.
  - WAIT_READY (2):
    - ready_s & done_s goes to RUN and clears RETRY_CNT.
    - lock_s=0 returns to WAIT_LOCK with no retry increment.
    - When counter==READY_TIMEOUT-1: go to FAULT if RETRY_CNT==MAX_RETRY; otherwise increment RETRY_CNT and go to WAIT_LOCK.
  - RUN (3): lock_s=0 or SOFT_RESET_REQ returns to WAIT_LOCK.
  - FAULT (4):
    - Terminal.
    - Only SOFT_RESET_REQ exits, to WAIT_LOCK, clearing RETRY_CNT.
- SOFT_RESET_REQ in WAIT_LOCK, HOLD or WAIT_READY restarts to WAIT_LOCK. The counter is cleared and RETRY_CNT is unchanged.
- Outputs are registered from next-state:
  - FAB_RESET_N=1 iff next state is WAIT_READY or RUN.
  - SYS_READY=1 iff next state is RUN.
  - FAULT=1 iff next state is FAULT.
- Simultaneous events:
  - In WAIT_READY, ready_s&done_s beats lock loss, and lock loss beats timeout.
  - In RUN, lock loss together with SOFT_RESET_REQ produces a single transition to WAIT_LOCK.
  - In FAULT, RESET and SOFT_RESET_REQ together: RESET wins, with an identical result.

## Timing
- Reset values (RESET high at an edge):
  - STATE=WAIT_LOCK, counter=0, RETRY_CNT=0.
  - FAB_RESET_N=0, SYS_READY=0, FAULT=0.
  - Synchronizer flops=0.
- RESET mid-operation forces the reset values at the next edge from any state.
- Input synchronization latency: 2 cycles.
- Lock path: CCC_LOCK rising at edge 0 gives lock_s=1 after edge 2. STATE=HOLD is visible after edge LOCK_FILTER+2.
- FAB_RESET_N rises HOLD_CYCLES cycles after HOLD entry, in the same cycle STATE shows WAIT_READY.
- Ready path: MSS_READY&INIT_DONE rising at edge t gives SYS_READY=1 after edge t+3.
- Lock loss in RUN: CCC_LOCK falling at edge t gives FAB_RESET_N=0 and SYS_READY=0 after edge t+3.
- SOFT_RESET_REQ at edge t gives FAB_RESET_N=0 after edge t+1.
- A lock_s glitch in WAIT_LOCK restarts the filter from 0. There is no partial credit.

## Structure
- Package fab_rst_seq_pkg holds:
  - the state enum and its 3-bit encoding;
  - the RETRY_CNT width constant;
  - a clog2-based counter-width function.
- Sub-module fab_sync2 is a 2-flop synchronizer with reset to 0, instantiated three times.

## Test plan
Bench parameters: LOCK_FILTER=4, HOLD_CYCLES=8, READY_TIMEOUT=32, MAX_RETRY=2.

- Nominal boot: CCC_LOCK rises at edge 0; MSS_READY and INIT_DONE rise at edge 20. Expect HOLD at edge 6, FAB_RESET_N=1 at edge 14, SYS_READY=1 at edge 23, RETRY_CNT=0.
- Lock glitch: CCC_LOCK low for 1 cycle at edge 4. Expect the filter to restart, HOLD delayed by 5 cycles, and FAB_RESET_N to remain 0 until then.
- Retry exhaustion: lock stays stable and MSS_READY is never asserted. Expect RETRY_CNT to step 1, 2, then FAULT=1 with FAB_RESET_N=0 after the 3rd timeout, and FAULT held indefinitely.
- Fault clear: SOFT_RESET_REQ pulse in FAULT. Expect STATE=0, RETRY_CNT=0, FAULT=0 next cycle, followed by the nominal sequence.
- Lock loss in RUN with SOFT_RESET_REQ in the same cycle: expect a single transition to WAIT_LOCK, SYS_READY=0 and FAB_RESET_N=0, and no RETRY_CNT change.
- Synchronous RESET asserted mid-HOLD for 1 cycle: expect all outputs at reset values the next cycle and sequence timing restarting from WAIT_LOCK.

Source files
------------

// File: rtl/fab_rst_seq_pkg.sv
// Shared types and sizing helpers for the fabric reset sequencer.
// The state encoding is visible on the STATE port, so it is fixed here.
package fab_rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK  = 3'd0,
        ST_HOLD       = 3'd1,
        ST_WAIT_READY = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAULT      = 3'd4
    } state_t;

    localparam int RETRY_W = 2;

    // One counter serves all three intervals, so it is sized by the largest one.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/fab_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Both flops clear on the synchronous reset.
module fab_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments make both flops sample pre-edge values, so this is a true 2-stage shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fab_reset_sequencer.sv
// Holds FAB_RESET_N low until the CCC lock is filtered and a hold-off has elapsed.
// It then waits for MSS ready/init done, with bounded retries and a latched fault.
module fab_reset_sequencer
    import fab_rst_seq_pkg::*;
#(
    parameter int LOCK_FILTER   = 16,
    parameter int HOLD_CYCLES   = 200,
    parameter int READY_TIMEOUT = 65535,
    parameter int MAX_RETRY     = 3
) (
    input  logic               CLK_BASE,
    input  logic               RESET,
    input  logic               CCC_LOCK,
    input  logic               MSS_READY,
    input  logic               INIT_DONE,
    input  logic               SOFT_RESET_REQ,
    output logic               FAB_RESET_N,
    output logic               SYS_READY,
    output logic               FAULT,
    output logic [2:0]         STATE,
    output logic [RETRY_W-1:0] RETRY_CNT
);

    localparam int CNT_W = cnt_width(LOCK_FILTER, HOLD_CYCLES, READY_TIMEOUT);

    localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(READY_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    logic lock_s;
    logic ready_s;
    logic done_s;

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [RETRY_W-1:0] retry_q, retry_n;

    fab_sync2 u_sync_lock  (.clk(CLK_BASE), .rst(RESET), .d(CCC_LOCK),  .q(lock_s));
    fab_sync2 u_sync_ready (.clk(CLK_BASE), .rst(RESET), .d(MSS_READY), .q(ready_s));
    fab_sync2 u_sync_done  (.clk(CLK_BASE), .rst(RESET), .d(INIT_DONE), .q(done_s));

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case can infer a latch.
        state_n = state_q;
        cnt_n   = cnt_q + 1'b1;
        retry_n = retry_q;

        case (state_q)
            ST_WAIT_LOCK: begin
                if (SOFT_RESET_REQ || !lock_s) begin
                    cnt_n = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_n = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (SOFT_RESET_REQ || !lock_s) begin
                    state_n = ST_WAIT_LOCK;
                end else if (cnt_q == HOLD_LAST) begin
                    state_n = ST_WAIT_READY;
                end
            end
            ST_WAIT_READY: begin
                // Readiness beats lock loss, which beats the timeout.
                if (SOFT_RESET_REQ) begin
                    state_n = ST_WAIT_LOCK;
                end else if (ready_s && done_s) begin
                    state_n = ST_RUN;
                    retry_n = '0;
                end else if (!lock_s) begin
                    state_n = ST_WAIT_LOCK;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_LIMIT) begin
                        state_n = ST_FAULT;
                    end else begin
                        state_n = ST_WAIT_LOCK;
                        retry_n = retry_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                cnt_n = '0;
                if (SOFT_RESET_REQ || !lock_s) begin
                    state_n = ST_WAIT_LOCK;
                end
            end
            ST_FAULT: begin
                cnt_n = '0;
                if (SOFT_RESET_REQ) begin
                    state_n = ST_WAIT_LOCK;
                    retry_n = '0;
                end
            end
            default: begin
                state_n = ST_WAIT_LOCK;
                cnt_n   = '0;
            end
        endcase

        if (state_n != state_q) begin
            cnt_n = '0;
        end
    end

    // Outputs are decoded from the next state so they change with STATE, not a cycle later.
    always_ff @(posedge CLK_BASE) begin
        if (RESET) begin
            state_q     <= ST_WAIT_LOCK;
            cnt_q       <= '0;
            retry_q     <= '0;
            FAB_RESET_N <= 1'b0;
            SYS_READY   <= 1'b0;
            FAULT       <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            retry_q     <= retry_n;
            FAB_RESET_N <= (state_n == ST_WAIT_READY) || (state_n == ST_RUN);
            SYS_READY   <= (state_n == ST_RUN);
            FAULT       <= (state_n == ST_FAULT);
        end
    end

    assign STATE     = state_q;
    assign RETRY_CNT = retry_q;

endmodule

// File: tb/tb_fab_reset_sequencer.sv
// Bench for fab_reset_sequencer: directed boot/retry/fault scenarios plus a random run.
// Every edge is also compared against a timestamp-based reference model.
module tb_fab_reset_sequencer;

    localparam int LF = 4;
    localparam int HC = 8;
    localparam int RT = 32;
    localparam int MR = 2;

    localparam int S_WL = 0;
    localparam int S_HD = 1;
    localparam int S_WR = 2;
    localparam int S_RN = 3;
    localparam int S_FT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ccc_lock = 1'b0;
    logic       mss_ready = 1'b0;
    logic       init_done = 1'b0;
    logic       soft_req = 1'b0;
    logic       fab_reset_n;
    logic       sys_ready;
    logic       fault;
    logic [2:0] state;
    logic [1:0] retry_cnt;

    always #5 clk = ~clk;

    fab_reset_sequencer #(
        .LOCK_FILTER  (LF),
        .HOLD_CYCLES  (HC),
        .READY_TIMEOUT(RT),
        .MAX_RETRY    (MR)
    ) dut (
        .CLK_BASE      (clk),
        .RESET         (rst),
        .CCC_LOCK      (ccc_lock),
        .MSS_READY     (mss_ready),
        .INIT_DONE     (init_done),
        .SOFT_RESET_REQ(soft_req),
        .FAB_RESET_N   (fab_reset_n),
        .SYS_READY     (sys_ready),
        .FAULT         (fault),
        .STATE         (state),
        .RETRY_CNT     (retry_cnt)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: each synchronized input is the raw value sampled two edges earlier;
    // intervals are measured as edges elapsed since the state was entered.
    bit lock_dl[$];
    bit rdy_dl[$];
    bit done_dl[$];
    int m_state  = S_WL;
    int m_retry  = 0;
    int m_enter  = 0;
    int m_streak = 0;
    bit m_frn    = 1'b0;
    bit m_sys    = 1'b0;
    bit m_flt    = 1'b0;

    function automatic void dl_clear();
        lock_dl.delete(); rdy_dl.delete(); done_dl.delete();
        for (int i = 0; i < 2; i++) begin
            lock_dl.push_back(1'b0); rdy_dl.push_back(1'b0); done_dl.push_back(1'b0);
        end
    endfunction

    function automatic void model_edge(input bit r, input bit lk, input bit rd,
                                       input bit dn, input bit sf);
        bit ls, rs, ds, restart;
        int nxt;
        ls = lock_dl.pop_front();
        rs = rdy_dl.pop_front();
        ds = done_dl.pop_front();
        lock_dl.push_back(lk);
        rdy_dl.push_back(rd);
        done_dl.push_back(dn);
        if (r) begin
            dl_clear();
            m_state = S_WL; m_retry = 0; m_enter = cyc; m_streak = 0;
            m_frn = 1'b0; m_sys = 1'b0; m_flt = 1'b0;
            return;
        end
        nxt = m_state;
        restart = 1'b0;
        case (m_state)
            S_WL: begin
                if (sf) restart = 1'b1;
                else begin
                    m_streak = ls ? m_streak + 1 : 0;
                    if (m_streak == LF) nxt = S_HD;
                end
            end
            S_HD: begin
                if (sf || !ls) nxt = S_WL;
                else if (cyc - m_enter == HC) nxt = S_WR;
            end
            S_WR: begin
                if (sf) nxt = S_WL;
                else if (rs && ds) begin nxt = S_RN; m_retry = 0; end
                else if (!ls) nxt = S_WL;
                else if (cyc - m_enter == RT) begin
                    if (m_retry == MR) nxt = S_FT;
                    else begin m_retry++; nxt = S_WL; end
                end
            end
            S_RN: if (sf || !ls) nxt = S_WL;
            default: if (sf) begin nxt = S_WL; m_retry = 0; end
        endcase
        if (nxt != m_state || restart) begin
            m_enter = cyc;
            m_streak = 0;
        end
        m_state = nxt;
        m_frn = (nxt == S_WR) || (nxt == S_RN);
        m_sys = (nxt == S_RN);
        m_flt = (nxt == S_FT);
    endfunction

    // Advance one clock edge, then compare every output against the model.
    task automatic tick();
        logic [7:0] got, exp;
        cyc++;
        model_edge(rst, ccc_lock, mss_ready, init_done, soft_req);
        @(posedge clk);
        #1;
        exp = {m_frn, m_sys, m_flt, 3'(m_state), 2'(m_retry)};
        got = {fab_reset_n, sys_ready, fault, state, retry_cnt};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL model_cycle%0d {frn,sys,flt,state,retry} got=%b exp=%b", cyc, got, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1; ccc_lock = 1'b0; mss_ready = 1'b0; init_done = 1'b0; soft_req = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ccc_lock = 1'b1; mss_ready = 1'b1; init_done = 1'b1; soft_req = 1'b1;
        tick();
        checks++;
        if ({fab_reset_n, sys_ready, fault} !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=000", {fab_reset_n, sys_ready, fault});
        end
        checks++;
        if (state !== 3'd0 || retry_cnt !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d/%0d exp=0/0", state, retry_cnt);
        end
        rst = 1'b0; ccc_lock = 1'b0; mss_ready = 1'b0; init_done = 1'b0; soft_req = 1'b0;
    endtask

    task automatic test_nominal();
        apply_reset();
        ccc_lock = 1'b1;
        for (int e = 1; e <= 26; e++) begin
            if (e == 21) begin mss_ready = 1'b1; init_done = 1'b1; end
            tick();
            if ((e == 5 && state !== 3'd0) || (e == 6 && state !== 3'd1)) begin
                failures++;
                $display("FAIL nominal_hold_edge%0d got=%0d", e, state);
            end
            if ((e == 13 && fab_reset_n !== 1'b0) || (e == 14 && (fab_reset_n !== 1'b1 || state !== 3'd2))) begin
                failures++;
                $display("FAIL nominal_fab_edge%0d got=%b/%0d", e, fab_reset_n, state);
            end
            if ((e == 22 && sys_ready !== 1'b0) || (e == 23 && (sys_ready !== 1'b1 || retry_cnt !== 2'd0))) begin
                failures++;
                $display("FAIL nominal_sys_edge%0d got=%b/%0d", e, sys_ready, retry_cnt);
            end
            if (e == 5 || e == 6 || e == 13 || e == 14 || e == 22 || e == 23) checks++;
        end
        mss_ready = 1'b0; init_done = 1'b0;
    endtask

    task automatic test_lock_glitch();
        apply_reset();
        ccc_lock = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            if (e == 5) ccc_lock = 1'b0;
            if (e == 6) ccc_lock = 1'b1;
            tick();
            if (e <= 11) begin
                checks++;
                if (fab_reset_n !== 1'b0) begin
                    failures++;
                    $display("FAIL glitch_fab_low_edge%0d got=%b exp=0", e, fab_reset_n);
                end
            end
            if (e == 7 || e == 10 || e == 11) begin
                checks++;
                if (state !== ((e == 11) ? 3'd1 : 3'd0)) begin
                    failures++;
                    $display("FAIL glitch_state_edge%0d got=%0d", e, state);
                end
            end
        end
    endtask

    task automatic run_to_fault(output int fault_at, output int r1_at, output int r2_at);
        apply_reset();
        ccc_lock = 1'b1;
        fault_at = -1; r1_at = -1; r2_at = -1;
        for (int e = 1; e <= 300 && fault_at < 0; e++) begin
            tick();
            if (retry_cnt == 2'd1 && r1_at < 0) r1_at = e;
            if (retry_cnt == 2'd2 && r2_at < 0) r2_at = e;
            if (fault === 1'b1) fault_at = e;
        end
    endtask

    task automatic test_retry_exhaustion();
        int fault_at, r1_at, r2_at;
        run_to_fault(fault_at, r1_at, r2_at);
        checks++;
        if (r1_at != LF + 2 + HC + RT) begin
            failures++;
            $display("FAIL retry1_edge got=%0d exp=%0d", r1_at, LF + 2 + HC + RT);
        end
        checks++;
        if (r2_at != LF + 2 + HC + RT + (RT + LF + HC)) begin
            failures++;
            $display("FAIL retry2_edge got=%0d exp=%0d", r2_at, LF + 2 + HC + RT + (RT + LF + HC));
        end
        checks++;
        if (fault_at != LF + 2 + HC + RT + MR * (RT + LF + HC)) begin
            failures++;
            $display("FAIL fault_edge got=%0d exp=%0d", fault_at, LF + 2 + HC + RT + MR * (RT + LF + HC));
        end
        checks++;
        if (fab_reset_n !== 1'b0 || retry_cnt !== 2'd2) begin
            failures++;
            $display("FAIL fault_outputs got=%b/%0d exp=0/2", fab_reset_n, retry_cnt);
        end
        for (int i = 0; i < 40; i++) begin
            ccc_lock  = 1'($urandom_range(0, 1));
            mss_ready = 1'($urandom_range(0, 1));
            init_done = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (fault !== 1'b1 || state !== 3'd4) begin
                failures++;
                $display("FAIL fault_held_%0d got=%b/%0d exp=1/4", i, fault, state);
            end
        end
    endtask

    task automatic test_fault_clear();
        ccc_lock = 1'b1; mss_ready = 1'b0; init_done = 1'b0;
        tick();
        tick();
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        checks++;
        if (state !== 3'd0 || retry_cnt !== 2'd0 || fault !== 1'b0) begin
            failures++;
            $display("FAIL fault_clear got=%0d/%0d/%b exp=0/0/0", state, retry_cnt, fault);
        end
        for (int e = 1; e <= 16; e++) begin
            if (e == 13) begin mss_ready = 1'b1; init_done = 1'b1; end
            tick();
            if (e == 3 || e == 4 || e == 12 || e == 15) checks++;
            if ((e == 3 && state !== 3'd0) || (e == 4 && state !== 3'd1) ||
                (e == 12 && fab_reset_n !== 1'b1) || (e == 15 && sys_ready !== 1'b1)) begin
                failures++;
                $display("FAIL clear_reboot_edge%0d got=%0d/%b/%b", e, state, fab_reset_n, sys_ready);
            end
        end
        mss_ready = 1'b0; init_done = 1'b0;
    endtask

    task automatic test_fault_reset_and_soft();
        int fault_at, r1_at, r2_at;
        run_to_fault(fault_at, r1_at, r2_at);
        rst = 1'b1; soft_req = 1'b1;
        tick();
        rst = 1'b0; soft_req = 1'b0;
        checks++;
        if ({fab_reset_n, sys_ready, fault, state, retry_cnt} !== 8'd0) begin
            failures++;
            $display("FAIL fault_reset_soft got=%b exp=0", {fab_reset_n, sys_ready, fault, state, retry_cnt});
        end
    endtask

    task automatic test_run_loss_with_soft();
        apply_reset();
        ccc_lock = 1'b1; mss_ready = 1'b1; init_done = 1'b1;
        for (int e = 1; e <= 16; e++) tick();
        checks++;
        if (state !== 3'd3 || sys_ready !== 1'b1) begin
            failures++;
            $display("FAIL run_reached got=%0d/%b exp=3/1", state, sys_ready);
        end
        ccc_lock = 1'b0;
        tick();
        tick();
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        checks++;
        if (state !== 3'd0 || sys_ready !== 1'b0 || fab_reset_n !== 1'b0 || retry_cnt !== 2'd0) begin
            failures++;
            $display("FAIL run_loss_soft got=%0d/%b/%b/%0d exp=0/0/0/0", state, sys_ready, fab_reset_n, retry_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (state !== 3'd0 || retry_cnt !== 2'd0) begin
                failures++;
                $display("FAIL run_loss_settle_%0d got=%0d/%0d exp=0/0", i, state, retry_cnt);
            end
        end
        mss_ready = 1'b0; init_done = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        apply_reset();
        ccc_lock = 1'b1;
        for (int e = 1; e <= 8; e++) tick();
        checks++;
        if (state !== 3'd1) begin
            failures++;
            $display("FAIL mid_hold_reached got=%0d exp=1", state);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({fab_reset_n, sys_ready, fault, state, retry_cnt} !== 8'd0) begin
            failures++;
            $display("FAIL mid_hold_reset got=%b exp=0", {fab_reset_n, sys_ready, fault, state, retry_cnt});
        end
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (e == 5 || e == 6 || e == 14) checks++;
            if ((e == 5 && state !== 3'd0) || (e == 6 && state !== 3'd1) ||
                (e == 14 && fab_reset_n !== 1'b1)) begin
                failures++;
                $display("FAIL mid_hold_restart_edge%0d got=%0d/%b", e, state, fab_reset_n);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            soft_req = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 39) == 0) ccc_lock  = ~ccc_lock;
            if ($urandom_range(0, 29) == 0) mss_ready = ~mss_ready;
            if ($urandom_range(0, 29) == 0) init_done = ~init_done;
            tick();
        end
        rst = 1'b0; soft_req = 1'b0;
    endtask

    initial begin
        dl_clear();
        test_reset();
        test_nominal();
        test_lock_glitch();
        test_retry_exhaustion();
        test_fault_clear();
        test_fault_reset_and_soft();
        test_run_loss_with_soft();
        test_reset_mid_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
